pe_feeder: RTL
==============

Name: pe_feeder

Overview:
Sequencer that drives one parallel matrix PE (the initiator side of the PE neuron/weight/ctl/vld_i → result/vld_o interface). On a start command it streams LEN 512-bit neuron and weight beats from two synchronous-read buffers into the PE, marks the last beat, and captures the PE result. It returns the per-job dot product on a valid/ready output. The PE accumulator is never cleared, so the feeder subtracts the previous job's running total.

Parameters:
ADDR_W, 10, buffer address width; addresses wrap modulo 2^ADDR_W
LEN_W, 10, width of job length (beats)
BUF_W, 512, neuron/weight beat width (16 x int32 lanes)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; the PE's rst_n is driven from the same source (~rst)
start  in  1  job request pulse; accepted only in IDLE
n_base  in  ADDR_W  neuron buffer start address
w_base  in  ADDR_W  weight buffer start address
len  in  LEN_W  beats in job
busy  out  1  high whenever state != IDLE
nbuf_rd_en  out  1  neuron buffer read enable
nbuf_addr  out  ADDR_W  neuron buffer address
nbuf_rdata  in  BUF_W  neuron data, valid 1 cycle after rd_en
wbuf_rd_en  out  1  weight buffer read enable
wbuf_addr  out  ADDR_W  weight buffer address
wbuf_rdata  in  BUF_W  weight data, valid 1 cycle after rd_en
pe_neuron  out  BUF_W  to PE neuron (pass-through of nbuf_rdata)
pe_weight  out  BUF_W  to PE weight (pass-through of wbuf_rdata)
pe_ctl  out  2  [0] first beat of job, [1] last beat of job
pe_vld_i  out  1  beat valid to PE
pe_result  in  32  PE running total
pe_vld_o  in  1  PE result valid
out_vld  out  1  job result valid
out_rdy  in  1  downstream accepts result
out_data  out  32  job result
err  out  1  sticky: pe_vld_o seen outside WAIT_RES

Behaviour:
- Reset: state IDLE; busy, nbuf_rd_en, wbuf_rd_en, pe_vld_i, pe_ctl, out_vld, err = 0; addresses, out_data, beat counter, base_total = 0. Reset mid-job aborts immediately; next cycle is IDLE; no partial result is emitted.
- States: IDLE, ISSUE, WAIT_RES, OUT.
- IDLE: start=1 latches n_base, w_base, len. len!=0 → ISSUE; len==0 → OUT with out_data=0 and no buffer or PE traffic. start is ignored in all other states.
- ISSUE: exactly len cycles. In cycle i (0..len-1), both rd_en=1, nbuf_addr=n_base+i and wbuf_addr=w_base+i (mod 2^ADDR_W). After the last read → WAIT_RES.
- Beat pipeline: pe_vld_i is rd_en registered (1 cycle late). pe_neuron/pe_weight are the buffer rdata, combinational. pe_ctl[0]=1 with the first pe_vld_i beat only; pe_ctl[1]=1 with the last pe_vld_i beat only. pe_ctl=0 whenever pe_vld_i=0; the PE raises vld_o after any ctl[1].
- len==1: first and last beat coincide, so pe_ctl=2'b11.
- WAIT_RES: on pe_vld_o=1, out_data = pe_result - base_total (mod 2^32); base_total = pe_result; go to OUT.
- OUT: out_vld=1; out_data held stable until out_rdy=1. Handshake completes on out_vld & out_rdy → IDLE; out_vld=0 the next cycle. A start in the same cycle as the handshake is ignored.
- Latency: start accepted at edge 0 → reads in cycles 1..L, PE beats in cycles 2..L+1, pe_vld_o in cycle L+2, out_vld from cycle L+3 (start→out_vld = L+3 with out_rdy high). Throughput is one job per L+4 cycles.
- Arithmetic: all additions and subtractions wrap; no saturation. base_total tracks the PE total exactly, because both reset together.
- err: set when pe_vld_o=1 in any state except WAIT_RES; cleared only by rst. It does not alter the FSM.

Test Plan:
- Reset: hold rst 3 cycles, then release → all outputs 0, busy=0; a start during rst is ignored.
- Single job, len=4, n_base=0x3FE, w_base=0x010, buffers = all lanes 1 × all lanes 2 → addresses 3FE,3FF,000,001 and 010..013; pe_ctl 01,00,00,10; out_vld at cycle 7; out_data=128.
- Back-to-back jobs, len=2 then len=3 (per-beat 32) → outputs 64 then 96, with pe_result 64 and 160; start pulses during busy are ignored.
- len=0 → out_vld in cycle 1, out_data=0, no rd_en or pe_vld_i activity; len=1 → pe_ctl=2'b11 on the single beat.
- Backpressure: out_rdy low for 5 cycles in OUT → out_vld and out_data held; completes when out_rdy rises; no new start accepted until IDLE.
- rst asserted in ISSUE mid-job, then a new len=2 job → clean result with base_total restarted at 0. A spurious pe_vld_o in IDLE sets err=1 and leaves the FSM unaffected.

Source files
------------

// File: rtl/pe_feeder.sv
// Sequencer feeding one matrix PE: streams len neuron/weight beats from two buffers and returns the job's dot product.
// start to out_vld is len+3 cycles; the result is held on out_data while out_rdy is low, and no new job starts until then.
module pe_feeder #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10,
   parameter int BUF_W  = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] n_base,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              nbuf_rd_en,
   output logic [ADDR_W-1:0] nbuf_addr,
   input  logic [BUF_W-1:0]  nbuf_rdata,
   output logic              wbuf_rd_en,
   output logic [ADDR_W-1:0] wbuf_addr,
   input  logic [BUF_W-1:0]  wbuf_rdata,
   output logic [BUF_W-1:0]  pe_neuron,
   output logic [BUF_W-1:0]  pe_weight,
   output logic [1:0]        pe_ctl,
   output logic              pe_vld_i,
   input  logic [31:0]       pe_result,
   input  logic              pe_vld_o,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [31:0]       out_data,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, OUT} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] n_base_q, w_base_q;
   logic [LEN_W-1:0]  len_q, cnt;
   logic [31:0]       base_total, out_data_q;
   logic              rd, last_rd;

   assign rd         = (state == ISSUE);
   assign last_rd    = (cnt == len_q - LEN_W'(1));
   assign busy       = (state != IDLE);
   assign nbuf_rd_en = rd;
   assign wbuf_rd_en = rd;
   assign nbuf_addr  = n_base_q + ADDR_W'(cnt);
   assign wbuf_addr  = w_base_q + ADDR_W'(cnt);
   assign pe_neuron  = nbuf_rdata;
   assign pe_weight  = wbuf_rdata;
   assign out_vld    = (state == OUT);
   assign out_data   = out_data_q;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (start) state_nx = (len == '0) ? OUT : ISSUE;
         ISSUE:    if (last_rd) state_nx = WAIT_RES;
         WAIT_RES: if (pe_vld_o) state_nx = OUT;
         OUT:      if (out_rdy) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         n_base_q   <= '0;
         w_base_q   <= '0;
         len_q      <= '0;
         cnt        <= '0;
         base_total <= '0;
         out_data_q <= '0;
         pe_vld_i   <= 1'b0;
         pe_ctl     <= 2'b00;
         err        <= 1'b0;
      end else begin
         state    <= state_nx;
         // Buffer reads are synchronous, so beat markers trail the read by one cycle.
         pe_vld_i <= rd;
         pe_ctl   <= rd ? {last_rd, cnt == '0} : 2'b00;
         case (state)
            IDLE: if (start) begin
               n_base_q   <= n_base;
               w_base_q   <= w_base;
               len_q      <= len;
               cnt        <= '0;
               out_data_q <= '0;
            end
            ISSUE: cnt <= cnt + LEN_W'(1);
            // The PE never clears its accumulator; the job result is the delta.
            WAIT_RES: if (pe_vld_o) begin
               out_data_q <= pe_result - base_total;
               base_total <= pe_result;
            end
            default: ;
         endcase
         if (pe_vld_o && state != WAIT_RES) err <= 1'b1;
      end
   end

endmodule
